// File: rtl/axi_wr_dma_ch.sv
`default_nettype none
//==============================================================================
// Module  : axi_wr_dma_ch
// Purpose : Write-back DMA channel. Buffers the conv output stream in a FIFO
//           and drains it to memory as AXI3 INCR bursts of up to BURST_LEN beats.
// Revision: 1.0 - initial release
//==============================================================================
module axi_wr_dma_ch #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_DA = 32,
    parameter int AXI_WIDTH_DS = 4,
    parameter int BURST_LEN    = 16,
    parameter int FIFO_DEPTH   = 32,
    parameter int CNT_W        = 24
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic [AXI_WIDTH_AD-1:0] i_base_addr,
    input  logic [CNT_W-1:0]        i_num_words,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [AXI_WIDTH_DA-1:0] s_data,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [AXI_WIDTH_AD-1:0] M_AWADDR,
    output logic [AXI_WIDTH_ID-1:0] M_AWID,
    output logic [7:0]              M_AWLEN,
    output logic [2:0]              M_AWSIZE,
    output logic [1:0]              M_AWBURST,
    output logic [1:0]              M_AWLOCK,
    output logic [3:0]              M_AWCACHE,
    output logic [2:0]              M_AWPROT,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    output logic [AXI_WIDTH_DA-1:0] M_WDATA,
    output logic [AXI_WIDTH_DS-1:0] M_WSTRB,
    output logic                    M_WLAST,
    output logic [AXI_WIDTH_ID-1:0] M_WID,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    input  logic [1:0]              M_BRESP,
    input  logic [AXI_WIDTH_ID-1:0] M_BID,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BL_W  = $clog2(BURST_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_AW   = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]        remaining_q, remaining_d;
    logic [BL_W-1:0]         blen_q, blen_d;
    logic [BL_W-1:0]         beat_q, beat_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    rdy_q;

    logic [AXI_WIDTH_DA-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]          count_q;
    logic                    push, pop, full;
    logic [BL_W-1:0]         blen_next;
    logic                    unused_bid;

    assign unused_bid = ^M_BID;

    // rdy_q keeps s_ready low while reset is asserted and releases it one cycle later.
    assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign s_ready = rdy_q && !full;
    assign push    = s_valid && s_ready;
    assign pop     = M_WVALID && M_WREADY;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign blen_next = (remaining_q >= CNT_W'(BURST_LEN)) ? BL_W'(BURST_LEN)
                                                          : remaining_q[BL_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            blen_q      <= '0;
            beat_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            blen_q      <= blen_d;
            beat_q      <= beat_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        blen_d      = blen_q;
        beat_d      = beat_q;
        busy_d      = busy_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && !busy_q) begin
                    addr_d      = i_base_addr;
                    remaining_d = i_num_words;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (i_num_words == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // Whole burst must be buffered so W beats never starve mid-burst.
                blen_d = blen_next;
                beat_d = '0;
                if (count_q >= (PTR_W+1)'(blen_next)) state_d = S_AW;
            end
            S_AW: begin
                if (M_AWREADY) state_d = S_W;
            end
            S_W: begin
                if (M_WREADY) begin
                    if (beat_q == blen_q - 1'b1) state_d = S_B;
                    else                         beat_d  = beat_q + 1'b1;
                end
            end
            S_B: begin
                if (M_BVALID) begin
                    if (M_BRESP != 2'b00) err_d = 1'b1;
                    addr_d      = addr_q + AXI_WIDTH_AD'({blen_q, 2'b00});
                    remaining_d = remaining_q - CNT_W'(blen_q);
                    state_d     = (remaining_q == CNT_W'(blen_q)) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign M_AWVALID = (state_q == S_AW);
    assign M_AWADDR  = addr_q;
    assign M_AWLEN   = (state_q == S_AW) ? 8'(blen_q - 1'b1) : 8'd0;
    assign M_AWID    = '0;
    assign M_AWSIZE  = 3'b010;
    assign M_AWBURST = 2'b01;
    assign M_AWLOCK  = 2'b00;
    assign M_AWCACHE = 4'h0;
    assign M_AWPROT  = 3'h0;
    assign M_WVALID  = (state_q == S_W);
    assign M_WDATA   = fifo_mem[rd_ptr_q];
    assign M_WSTRB   = '1;
    assign M_WLAST   = (state_q == S_W) && (beat_q == blen_q - 1'b1);
    assign M_WID     = '0;
    assign M_BREADY  = (state_q == S_B);
    assign o_busy    = busy_q;
    assign o_done    = (state_q == S_DONE);
    assign o_err     = err_q;

endmodule
`default_nettype wire
